// File: rtl/sat_addsub_pipe.sv
// Registered saturating add/subtract stage with a valid/ready handshake.
// The A operand comes either from the port or from an internal accumulator.
// The stage supports unsigned or two's-complement clamping, which is chosen
// per beat, and keeps a saturating count of overflow events.
module sat_addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_sub,
    input  logic             sat_enable,
    input  logic             sat_signed,
    input  logic             acc_mode,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             sat_hit,
    output logic [CNT_W-1:0] sat_count
);

    localparam logic [WIDTH-1:0] SMAX    = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic             sat_hit_q,   sat_hit_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0] sat_count_q, sat_count_d;

    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH:0]   sum_ext;
    logic             uns_ovf;
    logic             sgn_ovf;
    logic             ovf;
    logic [WIDTH-1:0] clamp_val;
    logic [WIDTH-1:0] res_sel;

    // A single output register: a new beat is taken once the current one leaves.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Arithmetic path: pick the operand, form the extended sum, then detect and clamp overflow.
    always_comb begin
        // A clear in the same cycle as an accumulate means the beat starts from zero.
        op_a = acc_mode ? (clr ? '0 : acc_q) : a;

        if (op_sub) begin
            sum_ext = {1'b0, op_a} - {1'b0, b};
        end else begin
            sum_ext = {1'b0, op_a} + {1'b0, b};
        end

        // Bit WIDTH of the zero-extended result is the carry on add and the borrow on sub.
        uns_ovf = sum_ext[WIDTH];

        if (op_sub) begin
            sgn_ovf = (op_a[WIDTH-1] != b[WIDTH-1]) && (sum_ext[WIDTH-1] != op_a[WIDTH-1]);
        end else begin
            sgn_ovf = (op_a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != op_a[WIDTH-1]);
        end

        ovf = sat_signed ? sgn_ovf : uns_ovf;

        // On signed overflow the sign of A gives the direction of the overflow.
        if (sat_signed) begin
            clamp_val = op_a[WIDTH-1] ? SMIN : SMAX;
        end else begin
            clamp_val = op_sub ? '0 : '1;
        end

        res_sel = (sat_enable && ovf) ? clamp_val : sum_ext[WIDTH-1:0];
    end

    // Output stage next state: load on accept, drain when downstream takes the beat.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        sat_hit_d   = sat_hit_q;
        if (accept) begin
            out_valid_d = 1'b1;
            result_d    = res_sel;
            sat_hit_d   = ovf;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Accumulator and event counter next state; clr wins over the held value.
    always_comb begin
        acc_d       = acc_q;
        sat_count_d = sat_count_q;

        if (accept && acc_mode) begin
            acc_d = res_sel;
        end else if (clr) begin
            acc_d = '0;
        end

        if (clr) begin
            sat_count_d = (accept && ovf) ? CNT_W'(1) : '0;
        end else if (accept && ovf && (sat_count_q != CNT_MAX)) begin
            sat_count_d = sat_count_q + CNT_W'(1);
        end
    end

    // State registers; reset drops any pending result immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            sat_hit_q   <= 1'b0;
            acc_q       <= '0;
            sat_count_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            sat_hit_q   <= sat_hit_d;
            acc_q       <= acc_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign sat_hit   = sat_hit_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_sat_addsub_pipe.sv
// Bench for sat_addsub_pipe at WIDTH=8. The main instance has an 8-bit counter.
// A second instance has a 2-bit counter, shares every input, and is used to
// watch the counter saturate.
module tb_sat_addsub_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_ready2;
    logic [7:0] a;
    logic [7:0] b;
    logic       op_sub;
    logic       sat_enable;
    logic       sat_signed;
    logic       acc_mode;
    logic       clr;
    logic       out_valid;
    logic       out_valid2;
    logic       out_ready;
    logic [7:0] result;
    logic [7:0] result2;
    logic       sat_hit;
    logic       sat_hit2;
    logic [7:0] sat_count;
    logic [1:0] sat_count2;

    int checks;
    int failures;

    // Expected state that the bench tracks on its own.
    bit exp_valid;
    int exp_res;
    bit exp_hit;
    int m_acc;
    int m_cnt;
    int m_cnt2;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        bit         sub;
        bit         sen;
        bit         ssg;
        logic [7:0] r;
        bit         h;
    } vec_t;

    sat_addsub_pipe #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op_sub(op_sub), .sat_enable(sat_enable), .sat_signed(sat_signed),
        .acc_mode(acc_mode), .clr(clr), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .sat_hit(sat_hit), .sat_count(sat_count)
    );

    sat_addsub_pipe #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .op_sub(op_sub), .sat_enable(sat_enable), .sat_signed(sat_signed),
        .acc_mode(acc_mode), .clr(clr), .out_valid(out_valid2), .out_ready(out_ready),
        .result(result2), .sat_hit(sat_hit2), .sat_count(sat_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plain integer arithmetic: range-check the exact sum against the representable range.
    function automatic void ref_calc(input int av, input int bv, input bit sub, input bit sen,
                                     input bit ssg, output int res, output bit hit);
        int x, y, s, lo, hi;
        x = av;
        y = bv;
        if (ssg) begin
            if (x > 127) x = x - 256;
            if (y > 127) y = y - 256;
            lo = -128;
            hi = 127;
        end else begin
            lo = 0;
            hi = 255;
        end
        s   = sub ? (x - y) : (x + y);
        hit = (s > hi) || (s < lo);
        if (hit && sen) res = (s > hi) ? hi : lo;
        else            res = s;
        res = res & 255;
    endfunction

    // Advance the expected state by one clock edge, using the inputs now on the bus.
    task automatic model_edge();
        int  opa;
        int  r;
        bit  h;
        bit  acc_now;
        acc_now = in_valid && (!exp_valid || out_ready);
        if (acc_now) begin
            opa = acc_mode ? (clr ? 0 : m_acc) : int'(a);
            ref_calc(opa, int'(b), op_sub, sat_enable, sat_signed, r, h);
            exp_res   = r;
            exp_hit   = h;
            exp_valid = 1'b1;
            if (acc_mode) m_acc = r;
            else if (clr) m_acc = 0;
            if (clr) begin
                m_cnt  = h ? 1 : 0;
                m_cnt2 = h ? 1 : 0;
            end else if (h) begin
                m_cnt  = (m_cnt  < 255) ? m_cnt + 1  : 255;
                m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
            end
        end else begin
            if (out_ready) exp_valid = 1'b0;
            if (clr) begin
                m_acc  = 0;
                m_cnt  = 0;
                m_cnt2 = 0;
            end
        end
    endtask

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_res   = 0;
        exp_hit   = 1'b0;
        m_acc     = 0;
        m_cnt     = 0;
        m_cnt2    = 0;
    endtask

    task automatic drive(input bit iv, input logic [7:0] av, input logic [7:0] bv, input bit sub,
                         input bit sen, input bit ssg, input bit am, input bit cl, input bit orr);
        in_valid   = iv;
        a          = av;
        b          = bv;
        op_sub     = sub;
        sat_enable = sen;
        sat_signed = ssg;
        acc_mode   = am;
        clr        = cl;
        out_ready  = orr;
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (result !== 8'h00) begin
            failures++;
            $display("FAIL reset_result got=%h exp=00", result);
        end
        checks++;
        if (sat_hit !== 1'b0) begin
            failures++;
            $display("FAIL reset_sat_hit got=%b exp=0", sat_hit);
        end
        checks++;
        if (sat_count !== 8'h00 || sat_count2 !== 2'b00) begin
            failures++;
            $display("FAIL reset_sat_count got=%h/%h exp=0", sat_count, sat_count2);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_directed();
        vec_t v[6];
        v[0] = '{a: 8'hF0, b: 8'h20, sub: 1'b0, sen: 1'b1, ssg: 1'b0, r: 8'hFF, h: 1'b1};
        v[1] = '{a: 8'hF0, b: 8'h20, sub: 1'b0, sen: 1'b0, ssg: 1'b0, r: 8'h10, h: 1'b1};
        v[2] = '{a: 8'h70, b: 8'h20, sub: 1'b0, sen: 1'b1, ssg: 1'b1, r: 8'h7F, h: 1'b1};
        v[3] = '{a: 8'h80, b: 8'h01, sub: 1'b1, sen: 1'b1, ssg: 1'b1, r: 8'h80, h: 1'b1};
        v[4] = '{a: 8'h05, b: 8'h09, sub: 1'b1, sen: 1'b1, ssg: 1'b0, r: 8'h00, h: 1'b1};
        v[5] = '{a: 8'h12, b: 8'h34, sub: 1'b0, sen: 1'b1, ssg: 1'b0, r: 8'h46, h: 1'b0};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, v[i].a, v[i].b, v[i].sub, v[i].sen, v[i].ssg, 1'b0, 1'b0, 1'b1);
            #1;
            model_edge();
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1) begin
                failures++;
                $display("FAIL dir_valid[%0d] got=%b exp=1", i, out_valid);
            end
            checks++;
            if (result !== v[i].r || result !== 8'(exp_res)) begin
                failures++;
                $display("FAIL dir_result[%0d] got=%h exp=%h", i, result, v[i].r);
            end
            checks++;
            if (sat_hit !== v[i].h) begin
                failures++;
                $display("FAIL dir_sat_hit[%0d] got=%b exp=%b", i, sat_hit, v[i].h);
            end
            checks++;
            if (sat_count !== 8'(m_cnt) || (i == 0 && sat_count !== 8'h01)) begin
                failures++;
                $display("FAIL dir_sat_count[%0d] got=%h exp=%h", i, sat_count, 8'(m_cnt));
            end
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        model_edge();
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL dir_drain got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 8'h10, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        model_edge();
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h30) begin
            failures++;
            $display("FAIL bp_first got=%b/%h exp=1/30", out_valid, result);
        end
        for (int i = 0; i < 3; i++) begin
            // The held beat must not follow the mode inputs while they move around.
            drive(1'b1, 8'h01, 8'h02, 1'(i & 1), 1'(i == 1), 1'(i == 2), 1'b0, 1'b0, 1'b0);
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready);
            end
            model_edge();
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || result !== 8'h30 || sat_hit !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d] got=%b/%h/%b exp=1/30/0", i, out_valid, result, sat_hit);
            end
        end
        drive(1'b1, 8'h01, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready got=%b exp=1", in_ready);
        end
        model_edge();
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h03 || result !== 8'(exp_res)) begin
            failures++;
            $display("FAIL bp_second got=%b/%h exp=1/03", out_valid, result);
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        model_edge();
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_no_duplicate got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_accumulate();
        logic [7:0] er[4];
        bit         eh[4];
        int         ec[4];
        er = '{8'h40, 8'h7F, 8'h7F, 8'h7F};
        eh = '{1'b0, 1'b1, 1'b1, 1'b1};
        ec = '{0, 1, 2, 3};
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        model_edge();
        @(posedge clk);
        #1;
        checks++;
        if (sat_count !== 8'h00) begin
            failures++;
            $display("FAIL acc_clr_idle got=%h exp=00", sat_count);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'($urandom), 8'h40, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            #1;
            model_edge();
            @(posedge clk);
            #1;
            checks++;
            if (result !== er[i] || sat_hit !== eh[i] || sat_count !== 8'(ec[i])) begin
                failures++;
                $display("FAIL acc_beat[%0d] got=%h/%b/%0d exp=%h/%b/%0d", i, result, sat_hit,
                         sat_count, er[i], eh[i], ec[i]);
            end
        end
        drive(1'b1, 8'($urandom), 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        model_edge();
        @(posedge clk);
        #1;
        checks++;
        if (result !== 8'h01 || sat_hit !== 1'b0 || sat_count !== 8'h00) begin
            failures++;
            $display("FAIL acc_clr_beat got=%h/%b/%0d exp=01/0/0", result, sat_hit, sat_count);
        end
        drive(1'b1, 8'($urandom), 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        model_edge();
        @(posedge clk);
        #1;
        checks++;
        if (result !== 8'h02 || result !== 8'(exp_res)) begin
            failures++;
            $display("FAIL acc_after_clr got=%h exp=02", result);
        end
    endtask

    task automatic test_cnt_sat();
        logic [1:0] ec2[6];
        ec2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        model_edge();
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            // The sixth beat does not overflow and must leave the held count alone.
            if (i < 5) drive(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            else       drive(1'b1, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            #1;
            model_edge();
            @(posedge clk);
            #1;
            checks++;
            if (sat_count2 !== ec2[i] || sat_count2 !== 2'(m_cnt2)) begin
                failures++;
                $display("FAIL cnt_sat2[%0d] got=%0d exp=%0d", i, sat_count2, ec2[i]);
            end
            checks++;
            if (sat_count !== 8'((i < 5) ? i + 1 : 5)) begin
                failures++;
                $display("FAIL cnt_sat8[%0d] got=%0d exp=%0d", i, sat_count, (i < 5) ? i + 1 : 5);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] av, bv;
        for (int i = 0; i < 600; i++) begin
            av = 8'($urandom);
            bv = 8'($urandom);
            if ($urandom_range(0, 3) == 0) av = ($urandom_range(0, 1) == 1) ? 8'h7F : 8'h80;
            if ($urandom_range(0, 3) == 0) bv = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h01;
            drive(1'($urandom_range(0, 3) != 0), av, bv, 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
            #1;
            checks++;
            if (in_ready !== (!exp_valid || out_ready) || in_ready2 !== in_ready) begin
                failures++;
                $display("FAIL rnd_in_ready[%0d] got=%b exp=%b", i, in_ready, !exp_valid || out_ready);
            end
            model_edge();
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== exp_valid) begin
                failures++;
                $display("FAIL rnd_out_valid[%0d] got=%b exp=%b", i, out_valid, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if (result !== 8'(exp_res) || sat_hit !== exp_hit) begin
                    failures++;
                    $display("FAIL rnd_result[%0d] got=%h/%b exp=%h/%b", i, result, sat_hit,
                             8'(exp_res), exp_hit);
                end
            end
            checks++;
            if (sat_count !== 8'(m_cnt) || sat_count2 !== 2'(m_cnt2)) begin
                failures++;
                $display("FAIL rnd_sat_count[%0d] got=%0d/%0d exp=%0d/%0d", i, sat_count,
                         sat_count2, m_cnt, m_cnt2);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 8'h00, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        model_edge();
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || result !== 8'(exp_res)) begin
            failures++;
            $display("FAIL ar_setup got=%b/%h exp=1/%h", out_valid, result, 8'(exp_res));
        end
        drive(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sat_count !== 8'h00 || sat_count2 !== 2'b00 || result !== 8'h00) begin
            failures++;
            $display("FAIL ar_immediate got=%b/%0d/%0d/%h exp=0/0/0/00", out_valid, sat_count,
                     sat_count2, result);
        end
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        drive(1'b1, 8'hAA, 8'h05, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        model_edge();
        @(posedge clk);
        #1;
        checks++;
        if (result !== 8'h05 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL ar_acc_cleared got=%b/%h exp=1/05", out_valid, result);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        test_reset();
        test_directed();
        test_backpressure();
        test_accumulate();
        test_cnt_sat();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sat_addsub_pipe.md
Name: sat_addsub_pipe

Overview:
- Parametrised, registered saturating add/subtract unit with a valid/ready handshake and an optional accumulate mode.
- Supports unsigned and two's-complement signed saturation at runtime, and reports a per-result saturation flag plus a saturating event counter.
- Sits at the adder output in the datapath, between the WIDTH-bit adder and downstream consumers.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 2)
- CNT_W, 8, width of saturation event counter (>= 1)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept operand beat
- a  input  WIDTH  operand A (ignored when acc_mode=1)
- b  input  WIDTH  operand B
- op_sub  input  1  0: A+B, 1: A-B
- sat_enable  input  1  1: clamp on overflow, 0: wrap
- sat_signed  input  1  1: two's-complement, 0: unsigned
- acc_mode  input  1  1: A operand is internal accumulator
- clr  input  1  synchronous clear of accumulator and counter
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- result  output  WIDTH  registered result
- sat_hit  output  1  overflow/underflow occurred for this result (valid with out_valid)
- sat_count  output  CNT_W  number of overflow events since reset/clr, saturating

Behaviour:
- Reset (rst_n=0, async): out_valid=0, result=0, sat_hit=0, sat_count=0, accumulator=0; in_ready=1 after release.
- in_ready = !out_valid || out_ready (single output register; full throughput, no bubble under continuous ready).
- Accept = in_valid && in_ready. On accept: result, sat_hit, and out_valid=1 are registered next edge. Latency 1 cycle.
- No accept and out_ready=1: out_valid clears. out_valid=1 and out_ready=0: result, sat_hit held stable.
- Operand A = acc_mode ? (clr ? 0 : acc) : a.
- Compute in WIDTH+1 bits.
- Unsigned overflow: carry out on add / borrow on sub.
- Signed overflow: operand signs agree (add) or differ (sub) and the result sign differs from A.
- Clamp when sat_enable=1 and overflow:
  - unsigned add -> all ones
  - unsigned sub -> 0
  - signed positive overflow -> 0 followed by ones (max positive)
  - signed negative overflow -> 1 followed by zeros (min negative)
- sat_enable=0: wrapped WIDTH-bit sum; sat_hit still reports overflow.
- Accumulator: on accept with acc_mode=1, acc <= clamped/wrapped result (same value as result). acc_mode=0 accepts leave acc unchanged.
- sat_count: increments by 1 on each accept with overflow; holds at all ones (no wrap).
- clr (synchronous, independent of handshake):
  - acc <= 0 and sat_count <= 0.
  - Same cycle as an accept: clr takes priority as the old value. acc <= 0 + b / 0 - b result, and sat_count <= (overflow ? 1 : 0).
  - clr does not affect out_valid or result.
- Mode inputs are sampled only on accept; changes mid-hold have no effect on a held result.
- Reset asserted mid-transfer: pending result discarded, out_valid=0 immediately.

Test Plan:
- WIDTH=8, unsigned add, sat_enable=1: a=0xF0, b=0x20 -> result=0xFF, sat_hit=1, sat_count=1. With sat_enable=0 -> result=0x10, sat_hit=1.
- Signed: a=0x70+b=0x20 -> 0x7F. a=0x80-b=0x01 -> 0x80. Unsigned 0x05-0x09 -> 0x00. All report sat_hit=1.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, result held constant. out_ready=1 -> next beat accepted the same cycle, no beat lost or duplicated.
- Accumulate: acc_mode=1, signed sat, b=0x40 four times -> results 0x40, 0x7F, 0x7F, 0x7F, sat_count=3. Then clr with b=0x01 same cycle -> result 0x01, sat_count=0.
- Counter saturation: CNT_W=2, 5 overflowing beats -> sat_count=3 and holds.
- Async reset asserted while out_valid=1, out_ready=0 -> out_valid=0, sat_count=0, acc=0 without a clock edge.
